s_mux_arb: RTL and testbench

Two-requester round-robin arbiter that owns the select line of a WIDTH-bit word multiplexer built from the sMUX gate. It sits between two producers sharing one downstream bus, such as the CPU and a loader both feeding the memory-input bus. It grants the bus in bounded bursts, steers the mux, and flags valid output words. The arbitration state is sequential; the data path is the combinational sMUX16 word mux.

---
 rtl/s_arb_pkg.sv | 15 +
 rtl/sMUX.sv | 12 +
 rtl/sMUX16.sv | 21 ++
 rtl/s_mux_arb.sv | 101 ++++++++++
 tb/tb_s_mux_arb.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/s_arb_pkg.sv
// Shared types for the two-requester bus arbiter:
// FSM state encodings and the burst counter width helper.
package s_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  function automatic int cnt_w(input int max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/sMUX.sv
// Single-bit 2:1 mux gate.
// sel=1 passes a, sel=0 passes b.
module sMUX (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? a : b;

endmodule

// File: rtl/sMUX16.sv
// Word-wide 2:1 mux built from one sMUX gate per bit,
// all bits sharing a single select line.
module sMUX16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sMUX u_mux (
      .a  (a[i]),
      .b  (b[i]),
      .sel(sel),
      .y  (y[i])
    );
  end

endmodule

// File: rtl/s_mux_arb.sv
// Round-robin burst arbiter for two producers sharing one bus;
// owns the select line of the sMUX16 word mux.
module s_mux_arb
  import s_arb_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             grant_a,
  output logic             grant_b,
  output logic             sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  localparam int CW = cnt_w(MAX_BURST);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  state_t          state;
  state_t          nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            last_a;
  logic            last_a_nxt;

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt + CW'(1);
    unique case (1'b1)
      (state == IDLE): begin
        cnt_nxt = '0;
        if (req_a && (!req_b || !last_a))
          nxt = OWN_A;
        else if (req_b)
          nxt = OWN_B;
      end
      (state == OWN_A): begin
        if (!req_a) begin
          nxt     = req_b ? OWN_B : IDLE;
          cnt_nxt = '0;
        end else if (cnt == LAST) begin
          // burst exhausted: hand over, or renew tenure
          cnt_nxt = '0;
          if (req_b)
            nxt = OWN_B;
        end
      end
      (state == OWN_B): begin
        if (!req_b) begin
          nxt     = req_a ? OWN_A : IDLE;
          cnt_nxt = '0;
        end else if (cnt == LAST) begin
          cnt_nxt = '0;
          if (req_a)
            nxt = OWN_A;
        end
      end
      default: begin
        nxt     = IDLE;
        cnt_nxt = '0;
      end
    endcase

    last_a_nxt = last_a;
    if (nxt == OWN_A && state != OWN_A)
      last_a_nxt = 1'b1;
    else if (nxt == OWN_B && state != OWN_B)
      last_a_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      last_a <= 1'b0;
    end else begin
      state  <= nxt;
      cnt    <= cnt_nxt;
      last_a <= last_a_nxt;
    end
  end

  assign grant_a   = (state == OWN_A);
  assign grant_b   = (state == OWN_B);
  assign sel       = grant_a;
  assign out_valid = (grant_a & req_a) | (grant_b & req_b);

  sMUX16 #(.WIDTH(WIDTH)) u_mux (
    .a  (data_a),
    .b  (data_b),
    .sel(sel),
    .y  (out_data)
  );

endmodule

// File: tb/tb_s_mux_arb.sv
// Directed and random checks of s_mux_arb with
// MAX_BURST=4 (u0) and MAX_BURST=1 (u1).
module tb_s_mux_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic [15:0] data_a = '0;
  logic [15:0] data_b = '0;

  logic        grant_a, grant_b, sel, out_valid;
  logic [15:0] out_data;
  logic        grant_a1, grant_b1, sel1, out_valid1;
  logic [15:0] out_data1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  s_mux_arb #(.WIDTH(16), .MAX_BURST(4)) u0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_a    (req_a),
    .req_b    (req_b),
    .data_a   (data_a),
    .data_b   (data_b),
    .grant_a  (grant_a),
    .grant_b  (grant_b),
    .sel      (sel),
    .out_data (out_data),
    .out_valid(out_valid)
  );

  s_mux_arb #(.WIDTH(16), .MAX_BURST(1)) u1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_a    (req_a),
    .req_b    (req_b),
    .data_a   (data_a),
    .data_b   (data_b),
    .grant_a  (grant_a1),
    .grant_b  (grant_b1),
    .sel      (sel1),
    .out_data (out_data1),
    .out_valid(out_valid1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // outputs packed as {grant_a, grant_b, sel, out_valid}
  task automatic test_reset();
    data_a = 16'h1111;
    data_b = 16'h2222;
    do_reset();
    @(negedge clk);
    checks++;
    if ({grant_a, grant_b, sel, out_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs got %b want 0000",
               {grant_a, grant_b, sel, out_valid});
    end
    checks++;
    if (out_data !== 16'h2222) begin
      errors++;
      $display("FAIL reset_data got %h want 2222", out_data);
    end
  endtask

  task automatic test_single_a();
    do_reset();
    req_a  = 1'b1;
    data_a = 16'hBEEF;
    for (int i = 0; i < 12; i++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({grant_a, grant_b, sel, out_valid} !== 4'b1011 ||
          out_data !== 16'hBEEF) begin
        errors++;
        $display("FAIL single_a cyc %0d got %b/%h want 1011/beef",
                 i, {grant_a, grant_b, sel, out_valid}, out_data);
      end
    end
    req_a = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({grant_a, grant_b, out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL single_a_idle got %b want 000",
               {grant_a, grant_b, out_valid});
    end
  endtask

  task automatic test_contention();
    logic exp_a;
    do_reset();
    req_a = 1'b1;
    req_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      @(negedge clk);
      exp_a = ((i / 4) % 2) == 0;
      checks++;
      if ({grant_a, grant_b, sel, out_valid} !== {exp_a, ~exp_a, exp_a, 1'b1}) begin
        errors++;
        $display("FAIL contention cyc %0d got %b want %b", i,
                 {grant_a, grant_b, sel, out_valid},
                 {exp_a, ~exp_a, exp_a, 1'b1});
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    req_a = 1'b1;
    tick();
    req_b = 1'b1;
    tick();
    req_a = 1'b0;
    @(negedge clk);
    checks++;
    if ({grant_a, grant_b, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL drop_valid got %b want 100",
               {grant_a, grant_b, out_valid});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({grant_a, grant_b, sel, out_valid} !== 4'b0101) begin
      errors++;
      $display("FAIL drop_handover got %b want 0101",
               {grant_a, grant_b, sel, out_valid});
    end
  endtask

  task automatic test_reset_mid();
    logic exp_a;
    do_reset();
    req_a = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    req_b = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({grant_a, grant_b, sel, out_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid got %b want 0000",
               {grant_a, grant_b, sel, out_valid});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      exp_a = (i < 4);
      checks++;
      if ({grant_a, grant_b} !== {exp_a, ~exp_a}) begin
        errors++;
        $display("FAIL reset_mid_regrant cyc %0d got %b want %b",
                 i, {grant_a, grant_b}, {exp_a, ~exp_a});
      end
    end
  endtask

  task automatic test_burst1();
    logic        exp_a;
    logic [15:0] exp_d;
    do_reset();
    data_a = 16'h0001;
    data_b = 16'h0002;
    req_a  = 1'b1;
    req_b  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      exp_a = (i % 2) == 0;
      exp_d = exp_a ? 16'h0001 : 16'h0002;
      checks++;
      if ({grant_a1, grant_b1, sel1, out_valid1} !== {exp_a, ~exp_a, exp_a, 1'b1} ||
          out_data1 !== exp_d) begin
        errors++;
        $display("FAIL burst1 cyc %0d got %b/%h want %b/%h", i,
                 {grant_a1, grant_b1, sel1, out_valid1}, out_data1,
                 {exp_a, ~exp_a, exp_a, 1'b1}, exp_d);
      end
    end
  endtask

  task automatic test_random();
    int wait_a = 0;
    int wait_b = 0;
    logic        exp_v;
    logic [15:0] exp_d;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      req_a  = ($urandom_range(0, 3) != 0);
      req_b  = ($urandom_range(0, 3) != 0);
      data_a = 16'($urandom);
      data_b = 16'($urandom);
      tick();
      @(negedge clk);
      exp_v = (grant_a & req_a) | (grant_b & req_b);
      exp_d = grant_a ? data_a : data_b;
      checks++;
      if ((grant_a & grant_b) !== 1'b0 || sel !== grant_a) begin
        errors++;
        $display("FAIL rnd_excl cyc %0d ga %b gb %b sel %b",
                 i, grant_a, grant_b, sel);
      end
      checks++;
      if (out_valid !== exp_v || out_data !== exp_d) begin
        errors++;
        $display("FAIL rnd_out cyc %0d got %b/%h want %b/%h",
                 i, out_valid, out_data, exp_v, exp_d);
      end
      wait_a = (req_a && !grant_a) ? wait_a + 1 : 0;
      wait_b = (req_b && !grant_b) ? wait_b + 1 : 0;
      checks++;
      if (wait_a > 5 || wait_b > 5) begin
        errors++;
        $display("FAIL rnd_wait cyc %0d wait_a %0d wait_b %0d max 5",
                 i, wait_a, wait_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_contention();
    test_drop();
    test_reset_mid();
    test_burst1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
